// File: rtl/multi_clk_gen_pkg.sv
// Shared types and helpers for the multi-channel clock generator.
//   ch_state_t    : per-channel FSM state
//   sanitize_half : maps a zero half-period onto 1 so a channel can never stall
package multi_clk_gen_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PHASE = 2'd1,
      RUN   = 2'd2,
      STOP  = 2'd3
   } ch_state_t;

   localparam int unsigned HALF_FN_W = 32;

   function automatic logic [HALF_FN_W-1:0] sanitize_half(input logic [HALF_FN_W-1:0] half);
      return (half == '0) ? HALF_FN_W'(1) : half;
   endfunction

endpackage

// File: rtl/clk_gen_channel.sv
// One generated clock channel: FSM, half-period/phase counter, shadow config.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   i_en              run enable (level)
//   i_sync            realign pulse
//   i_wr              config write accepted for this channel this cycle
//   i_half, i_phase   write payload
//   o_pending         shadow holds a config not yet applied
//   o_clk, o_tick     generated clock and its change strobe (registered)
module clk_gen_channel #(
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned DEFAULT_HALF = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_sync,
   input  logic             i_wr,
   input  logic [CNT_W-1:0] i_half,
   input  logic [CNT_W-1:0] i_phase,
   output logic             o_pending,
   output logic             o_clk,
   output logic             o_tick
);
   import multi_clk_gen_pkg::*;

   localparam logic [CNT_W-1:0] RST_HALF =
      CNT_W'(sanitize_half(HALF_FN_W'(DEFAULT_HALF)));

   ch_state_t        r_state,    w_state_nx;
   logic [CNT_W-1:0] r_cnt,      w_cnt_nx;
   logic [CNT_W-1:0] r_half,     w_half_nx;
   logic [CNT_W-1:0] r_phase,    w_phase_nx;
   logic [CNT_W-1:0] r_sh_half,  w_sh_half_nx;
   logic [CNT_W-1:0] r_sh_phase, w_sh_phase_nx;
   logic             r_pending,  w_pending_nx;
   logic             r_clk,      w_clk_nx;
   logic             r_tick,     w_tick_nx;

   logic             w_apply_all;
   logic             w_apply_pend;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_hit;
   logic [CNT_W-1:0] w_wr_half;
   logic             w_eff_valid;
   logic [CNT_W-1:0] w_eff_half;
   logic [CNT_W-1:0] w_eff_phase;
   logic [CNT_W-1:0] w_start_phase;
   ch_state_t        w_start_state;

   assign w_cnt_inc   = r_cnt + CNT_W'(1);
   assign w_hit       = (r_cnt == r_half - CNT_W'(1));
   assign w_wr_half   = CNT_W'(sanitize_half(HALF_FN_W'(i_half)));

   // Config seen by a (re)start: a same-cycle write beats the shadow, which beats current
   assign w_eff_valid   = i_wr | r_pending;
   assign w_eff_half    = i_wr ? w_wr_half : r_sh_half;
   assign w_eff_phase   = i_wr ? i_phase   : r_sh_phase;
   assign w_start_phase = w_eff_valid ? w_eff_phase : r_phase;
   assign w_start_state = (w_start_phase == '0) ? RUN : PHASE;

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_half     <= RST_HALF;
         r_phase    <= '0;
         r_sh_half  <= RST_HALF;
         r_sh_phase <= '0;
         r_pending  <= 1'b0;
         r_clk      <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_cnt      <= w_cnt_nx;
         r_half     <= w_half_nx;
         r_phase    <= w_phase_nx;
         r_sh_half  <= w_sh_half_nx;
         r_sh_phase <= w_sh_phase_nx;
         r_pending  <= w_pending_nx;
         r_clk      <= w_clk_nx;
         r_tick     <= w_tick_nx;
      end
   end

   // Next-state, counter and config-apply logic
   always_comb begin
      w_state_nx    = r_state;
      w_cnt_nx      = r_cnt;
      w_half_nx     = r_half;
      w_phase_nx    = r_phase;
      w_sh_half_nx  = r_sh_half;
      w_sh_phase_nx = r_sh_phase;
      w_pending_nx  = r_pending;
      w_clk_nx      = r_clk;
      w_tick_nx     = 1'b0;
      w_apply_all   = 1'b0;
      w_apply_pend  = 1'b0;

      if (i_sync) begin
         // Realign; a disabled channel is forced low even mid high-phase
         w_apply_all = 1'b1;
         w_cnt_nx    = '0;
         w_clk_nx    = 1'b0;
         w_tick_nx   = r_clk;
         w_state_nx  = i_en ? w_start_state : IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               w_cnt_nx = '0;
               if (i_en) begin
                  w_apply_all = 1'b1;
                  w_state_nx  = w_start_state;
               end else begin
                  w_apply_pend = 1'b1;
               end
            end
            PHASE: begin
               if (!i_en) begin
                  w_state_nx = IDLE;
                  w_cnt_nx   = '0;
               end else if (r_cnt == r_phase - CNT_W'(1)) begin
                  w_state_nx = RUN;
                  w_cnt_nx   = '0;
               end else begin
                  w_cnt_nx = w_cnt_inc;
               end
            end
            RUN: begin
               if (!i_en && !r_clk) begin
                  w_state_nx = IDLE;
                  w_cnt_nx   = '0;
               end else if (w_hit) begin
                  w_clk_nx     = ~r_clk;
                  w_tick_nx    = 1'b1;
                  w_cnt_nx     = '0;
                  w_apply_pend = 1'b1;
                  if (!i_en) w_state_nx = IDLE;
               end else begin
                  w_cnt_nx = w_cnt_inc;
                  if (!i_en) w_state_nx = STOP;
               end
            end
            STOP: begin
               // Finish the high phase so the last pulse is never a runt
               if (w_hit) begin
                  w_clk_nx     = 1'b0;
                  w_tick_nx    = 1'b1;
                  w_cnt_nx     = '0;
                  w_apply_pend = 1'b1;
                  w_state_nx   = IDLE;
               end else begin
                  w_cnt_nx = w_cnt_inc;
               end
            end
            default: begin
               w_state_nx = IDLE;
               w_cnt_nx   = '0;
               w_clk_nx   = 1'b0;
            end
         endcase
      end

      // Apply shadow config; a write landing on a toggle waits for the next one
      if (w_apply_all) begin
         if (w_eff_valid) begin
            w_half_nx  = w_eff_half;
            w_phase_nx = w_eff_phase;
         end
         w_pending_nx = 1'b0;
      end else begin
         if (w_apply_pend && r_pending) begin
            w_half_nx    = r_sh_half;
            w_phase_nx   = r_sh_phase;
            w_pending_nx = 1'b0;
         end
         if (i_wr) begin
            w_sh_half_nx  = w_wr_half;
            w_sh_phase_nx = i_phase;
            w_pending_nx  = 1'b1;
         end
      end
   end

   assign o_pending = r_pending;
   assign o_clk     = r_clk;
   assign o_tick    = r_tick;

endmodule

// File: rtl/multi_clk_gen.sv
// Multi-channel clock generator: NUM_CH independent divided clocks from clk.
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   ch_en                  per-channel run enable
//   sync_start             realign all enabled channels to phase origin
//   cfg_valid/cfg_ready    config write handshake (ready is combinational on cfg_ch)
//   cfg_ch, cfg_half, cfg_phase  target channel and new half-period / phase
//   clk_out, tick          generated clocks and change strobes (registered)
module multi_clk_gen #(
   parameter  int unsigned NUM_CH       = 2,
   parameter  int unsigned CNT_W        = 8,
   parameter  int unsigned DEFAULT_HALF = 20,
   localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync_start,
   input  logic              cfg_valid,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_half,
   input  logic [CNT_W-1:0]  cfg_phase,
   output logic              cfg_ready,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);
   import multi_clk_gen_pkg::*;

   logic [NUM_CH-1:0] w_pending;
   logic [NUM_CH-1:0] w_wr;

   // Ready mux; a channel index beyond NUM_CH reads as ready and the write is dropped
   always_comb begin
      cfg_ready = 1'b1;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) cfg_ready = ~w_pending[i];
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_wr[g] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));

      clk_gen_channel #(
         .CNT_W        (CNT_W),
         .DEFAULT_HALF (DEFAULT_HALF)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .i_en      (ch_en[g]),
         .i_sync    (sync_start),
         .i_wr      (w_wr[g]),
         .i_half    (cfg_half),
         .i_phase   (cfg_phase),
         .o_pending (w_pending[g]),
         .o_clk     (clk_out[g]),
         .o_tick    (tick[g])
      );
   end

endmodule
